// File: rtl/qam_pkg.sv
// rtl/qam_pkg.sv - shared widths, FSM encoding, sign-bit indices and quarter-sine helpers
package qam_pkg;
    localparam int PHASE_W  = 8;
    localparam int LUT_AW   = 6;
    localparam int SAMPLE_W = 9;
    localparam int MAG_W    = SAMPLE_W - 1;
    localparam int LUT_N    = (1 << LUT_AW) + 1;
    localparam int SIN_SGN  = 1;
    localparam int COS_SGN  = 0;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} qam_state_e;

    // round(amp * sin(idx*pi/128)) from a Q30 Taylor series; only ever called with constants
    function automatic logic [MAG_W-1:0] quarter_sine(input int idx, input int amp);
        longint one, x, x2, t, s;
        one = 64'sd1 <<< 30;
        x   = (longint'(idx) * 64'sd3373259426) / 64'sd128;
        x2  = (x * x) >>> 30;
        t   = one - x2 / 64'sd110;
        t   = one - ((x2 * t) >>> 30) / 64'sd72;
        t   = one - ((x2 * t) >>> 30) / 64'sd42;
        t   = one - ((x2 * t) >>> 30) / 64'sd20;
        t   = one - ((x2 * t) >>> 30) / 64'sd6;
        s   = (x * t) >>> 30;
        return MAG_W'((s * longint'(amp) + (one >>> 1)) >>> 30);
    endfunction

    // Odd quadrants read the table mirrored: address 64-a instead of a.
    function automatic logic [LUT_AW:0] lut_addr(input logic [LUT_AW:0] ph_lo);
        logic [LUT_AW:0] a;
        a = {1'b0, ph_lo[LUT_AW-1:0]};
        return ph_lo[LUT_AW] ? (LUT_AW+1)'(LUT_N - 1) - a : a;
    endfunction
endpackage

// File: rtl/qam_iq_modulator_if.sv
// rtl/qam_iq_modulator_if.sv - symbol input / modulated sample output bundle
interface qam_iq_modulator_if;
    import qam_pkg::*;

    logic [1:0]                 elojel_sin_cos;
    logic                       data_change_cntr;
    logic signed [SAMPLE_W-1:0] qam_out;
    logic                       out_valid;
    logic                       sym_load;
    logic                       overrun;

    modport master (
        output elojel_sin_cos, data_change_cntr,
        input  qam_out, out_valid, sym_load, overrun
    );

    modport slave (
        input  elojel_sin_cos, data_change_cntr,
        output qam_out, out_valid, sym_load, overrun
    );
endinterface

// File: rtl/sine_quarter_lut.sv
// rtl/sine_quarter_lut.sv - registered 65-entry quarter-wave sine ROM with two read ports
module sine_quarter_lut
    import qam_pkg::*;
#(
    parameter int AMP = 127
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [LUT_AW:0]  sin_addr,
    input  logic [LUT_AW:0]  cos_addr,
    output logic [MAG_W-1:0] sin_mag_q,
    output logic [MAG_W-1:0] cos_mag_q
);
    logic [MAG_W-1:0] rom [LUT_N];
    logic [MAG_W-1:0] sin_mag_d;
    logic [MAG_W-1:0] cos_mag_d;

    for (genvar i = 0; i < LUT_N; i++) begin : g_rom
        assign rom[i] = quarter_sine(i, AMP);
    end

    always_comb begin
        sin_mag_d = rom[sin_addr];
        cos_mag_d = rom[cos_addr];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sin_mag_q <= '0;
            cos_mag_q <= '0;
        end else begin
            sin_mag_q <= sin_mag_d;
            cos_mag_q <= cos_mag_d;
        end
    end
endmodule

// File: rtl/qam_iq_modulator.sv
// rtl/qam_iq_modulator.sv - QPSK modulator: +/-sin +/-cos carrier, symbols switch at period wrap
module qam_iq_modulator
    import qam_pkg::*;
#(
    parameter int PHASE_INC = 4,
    parameter int AMP       = 127
) (
    input  logic               clock,
    input  logic               reset,
    qam_iq_modulator_if.slave  bus
);
    qam_state_e                 state_q, state_d;
    logic [PHASE_W-1:0]         ph_q, ph_d;
    logic [1:0]                 active_q, active_d;
    logic [1:0]                 pending_q, pending_d;
    logic                       pend_full_q, pend_full_d;
    logic                       sym_load_q, sym_load_d;
    logic                       overrun_q, overrun_d;
    logic                       sin_neg_q, sin_neg_d;
    logic                       cos_neg_q, cos_neg_d;
    logic                       s1_valid_q, s1_valid_d;
    logic signed [SAMPLE_W-1:0] qam_out_q, qam_out_d;
    logic                       out_valid_q, out_valid_d;

    logic [PHASE_W:0]           ph_sum;
    logic                       wrap;
    logic                       strobe;
    logic [PHASE_W-1:0]         ph_cos;
    logic [MAG_W-1:0]           sin_mag_q, cos_mag_q;
    logic signed [SAMPLE_W-1:0] sin_term, cos_term;

    assign strobe = bus.data_change_cntr;
    assign ph_sum = {1'b0, ph_q} + (PHASE_W+1)'(PHASE_INC);
    assign wrap   = ph_sum[PHASE_W];
    assign ph_cos = ph_q + PHASE_W'(1 << LUT_AW);

    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        active_d    = active_q;
        pending_d   = pending_q;
        pend_full_d = pend_full_q;
        sym_load_d  = 1'b0;
        overrun_d   = overrun_q;
        case (state_q)
            IDLE: begin
                if (strobe) begin
                    state_d    = RUN;
                    active_d   = bus.elojel_sin_cos;
                    sym_load_d = 1'b1;
                end
            end
            RUN: begin
                ph_d = ph_sum[PHASE_W-1:0];
                if (wrap) begin
                    // A symbol arriving on the wrap cycle is newer than anything pending
                    if (strobe) begin
                        active_d   = bus.elojel_sin_cos;
                        sym_load_d = 1'b1;
                    end else if (pend_full_q) begin
                        active_d   = pending_q;
                        sym_load_d = 1'b1;
                    end
                    pend_full_d = 1'b0;
                end else if (strobe) begin
                    pending_d   = bus.elojel_sin_cos;
                    pend_full_d = 1'b1;
                    overrun_d   = overrun_q | pend_full_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    sine_quarter_lut #(.AMP(AMP)) u_lut (
        .clock     (clock),
        .reset     (reset),
        .sin_addr  (lut_addr(ph_q[LUT_AW:0])),
        .cos_addr  (lut_addr(ph_cos[LUT_AW:0])),
        .sin_mag_q (sin_mag_q),
        .cos_mag_q (cos_mag_q)
    );

    always_comb begin
        sin_neg_d   = ph_q[PHASE_W-1] ^ active_q[SIN_SGN];
        cos_neg_d   = ph_cos[PHASE_W-1] ^ active_q[COS_SGN];
        s1_valid_d  = (state_q == RUN);
        sin_term    = $signed({1'b0, sin_mag_q});
        cos_term    = $signed({1'b0, cos_mag_q});
        if (sin_neg_q) sin_term = -sin_term;
        if (cos_neg_q) cos_term = -cos_term;
        qam_out_d   = s1_valid_q ? sin_term + cos_term : '0;
        out_valid_d = s1_valid_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ph_q        <= '0;
            active_q    <= '0;
            pending_q   <= '0;
            pend_full_q <= 1'b0;
            sym_load_q  <= 1'b0;
            overrun_q   <= 1'b0;
            sin_neg_q   <= 1'b0;
            cos_neg_q   <= 1'b0;
            s1_valid_q  <= 1'b0;
            qam_out_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            pend_full_q <= pend_full_d;
            sym_load_q  <= sym_load_d;
            overrun_q   <= overrun_d;
            sin_neg_q   <= sin_neg_d;
            cos_neg_q   <= cos_neg_d;
            s1_valid_q  <= s1_valid_d;
            qam_out_q   <= qam_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.qam_out   = qam_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sym_load  = sym_load_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_qam_iq_modulator.sv
// tb/tb_qam_iq_modulator.sv - checks two modulators (step 4 and step 7) against a $sin/$cos model
module tb_qam_iq_modulator;
    localparam real PI  = 3.14159265358979323846;
    localparam real AMP = 127.0;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       strb  = 1'b0;
    logic [1:0] sym   = 2'b00;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    qam_iq_modulator_if bus0 ();
    qam_iq_modulator_if bus1 ();

    qam_iq_modulator #(.PHASE_INC(4), .AMP(127)) dut0 (.clock(clock), .reset(reset), .bus(bus0));
    qam_iq_modulator #(.PHASE_INC(7), .AMP(127)) dut1 (.clock(clock), .reset(reset), .bus(bus1));

    assign bus0.elojel_sin_cos   = sym;
    assign bus0.data_change_cntr = strb;
    assign bus1.elojel_sin_cos   = sym;
    assign bus1.data_change_cntr = strb;

    logic signed [8:0] act_out [2];
    logic              act_vld [2];
    logic              act_sl  [2];
    logic              act_ovr [2];
    assign act_out[0] = bus0.qam_out;
    assign act_out[1] = bus1.qam_out;
    assign act_vld[0] = bus0.out_valid;
    assign act_vld[1] = bus1.out_valid;
    assign act_sl[0]  = bus0.sym_load;
    assign act_sl[1]  = bus1.sym_load;
    assign act_ovr[0] = bus0.overrun;
    assign act_ovr[1] = bus1.overrun;

    always #5 clock = ~clock;

    // Behavioural model: phase as an integer, sample from real-valued trig.
    int         inc    [2] = '{4, 7};
    int         m_ph   [2];
    logic       m_run  [2];
    logic [1:0] m_act  [2];
    logic [1:0] m_pend [2];
    logic       m_pf   [2];
    logic       m_ovr  [2];
    logic       m_sl   [2];
    int         m_mid  [2];
    int         m_out  [2];
    logic       m_vmid [2];
    logic       m_vout [2];

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    function automatic int sample(input int ph, input logic [1:0] s);
        real th;
        int  sv, cv;
        th = 2.0 * PI * real'(ph) / 256.0;
        sv = rnd(AMP * $sin(th));
        cv = rnd(AMP * $cos(th));
        return (s[1] ? -sv : sv) + (s[0] ? -cv : cv);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ph[k] = 0; m_run[k] = 1'b0; m_act[k] = 2'b00; m_pend[k] = 2'b00;
            m_pf[k] = 1'b0; m_ovr[k] = 1'b0; m_sl[k] = 1'b0;
            m_mid[k] = 0; m_out[k] = 0; m_vmid[k] = 1'b0; m_vout[k] = 1'b0;
        end
    endtask

    task automatic model_step(input logic st, input logic [1:0] s);
        int nxt;
        for (int k = 0; k < 2; k++) begin
            m_out[k]  = m_mid[k];
            m_vout[k] = m_vmid[k];
            m_vmid[k] = m_run[k];
            m_mid[k]  = m_run[k] ? sample(m_ph[k], m_act[k]) : 0;
            m_sl[k]   = 1'b0;
            if (!m_run[k]) begin
                if (st) begin
                    m_run[k] = 1'b1; m_act[k] = s; m_sl[k] = 1'b1;
                end
            end else begin
                nxt = m_ph[k] + inc[k];
                if (nxt >= 256) begin
                    m_ph[k] = nxt - 256;
                    if (st) begin
                        m_act[k] = s; m_sl[k] = 1'b1;
                    end else if (m_pf[k]) begin
                        m_act[k] = m_pend[k]; m_sl[k] = 1'b1;
                    end
                    m_pf[k] = 1'b0;
                end else begin
                    m_ph[k] = nxt;
                    if (st) begin
                        m_ovr[k] = m_ovr[k] | m_pf[k]; m_pend[k] = s; m_pf[k] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string name, input int k, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s inst%0d @%0t: got %0d, want %0d", name, k, $time, act, exp);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clock);
            if (!reset) model_reset();
            for (int k = 0; k < 2; k++) begin
                chk("qam_out",   k, int'(act_out[k]), m_out[k]);
                chk("out_valid", k, int'(act_vld[k]), int'(m_vout[k]));
                chk("sym_load",  k, int'(act_sl[k]),  int'(m_sl[k]));
                chk("overrun",   k, int'(act_ovr[k]), int'(m_ovr[k]));
            end
            if (reset) model_step(strb, sym);
        end
    end

    task automatic step_to(input int c);
        while (cyc < c) begin
            @(posedge clock);
            #1;
            cyc++;
        end
    endtask

    task automatic pulse(input logic [1:0] s);
        sym  = s;
        strb = 1'b1;
        step_to(cyc + 1);
        strb = 1'b0;
    endtask

    initial begin
        chk("model_ph32_00", 0, sample(32, 2'b00), 180);
        chk("model_ph0_11",  0, sample(0, 2'b11), -127);
        chk("model_ph43_00", 0, sample(43, 2'b00), 174);

        #2 reset = 1'b0;
        #1;
        chk("rst_qam_out", 0, int'(act_out[0]), 0);
        chk("rst_valid",   0, int'(act_vld[0]), 0);
        chk("rst_overrun", 0, int'(act_ovr[0]), 0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;

        cyc = 0;
        step_to(200);
        chk("idle_qam_out", 0, int'(act_out[0]), 0);
        chk("idle_valid",   0, int'(act_vld[0]), 0);

        cyc = 0;
        pulse(2'b00);
        chk("first_sym_load", 0, int'(act_sl[0]), 1);
        step_to(2);
        chk("valid_not_yet", 0, int'(act_vld[0]), 0);
        step_to(3);
        chk("first_valid", 0, int'(act_vld[0]), 1);
        chk("s00_ph0",  0, int'(act_out[0]), 127);
        step_to(11);
        chk("s00_ph32", 0, int'(act_out[0]), 180);
        step_to(19);
        chk("s00_ph64", 0, int'(act_out[0]), 127);

        step_to(29);
        pulse(2'b11);
        step_to(65);
        chk("wrap_sym_load", 0, int'(act_sl[0]), 1);
        step_to(67);
        chk("s11_ph0", 0, int'(act_out[0]), -127);

        step_to(80);
        pulse(2'b10);
        step_to(131);
        chk("s10_ph0", 0, int'(act_out[0]), 127);

        step_to(140);
        pulse(2'b01);
        step_to(195);
        chk("s01_ph0", 0, int'(act_out[0]), -127);

        step_to(200);
        pulse(2'b10);
        step_to(210);
        pulse(2'b11);
        chk("overrun_set", 0, int'(act_ovr[0]), 1);
        step_to(257);
        chk("ovr_sym_load", 0, int'(act_sl[0]), 1);
        step_to(259);
        chk("ovr_applied_11", 0, int'(act_out[0]), -127);
        chk("overrun_sticky", 0, int'(act_ovr[0]), 1);

        step_to(320);
        pulse(2'b00);
        chk("bypass_sym_load", 0, int'(act_sl[0]), 1);
        step_to(323);
        chk("bypass_ph0", 0, int'(act_out[0]), 127);
        step_to(385);
        chk("bypass_no_reload", 0, int'(act_sl[0]), 0);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(15) == 0) begin
                sym  = 2'($urandom_range(3));
                strb = 1'b1;
            end else begin
                strb = 1'b0;
            end
            @(posedge clock);
            #1;
        end
        strb = 1'b0;
        chk("overrun_before_rst", 0, int'(act_ovr[0]), 1);

        @(posedge clock);
        #3 reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("async_qam_out",  k, int'(act_out[k]), 0);
            chk("async_valid",    k, int'(act_vld[k]), 0);
            chk("async_sym_load", k, int'(act_sl[k]),  0);
            chk("async_overrun",  k, int'(act_ovr[k]), 0);
        end
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;

        cyc = 0;
        step_to(50);
        chk("reidle_valid", 0, int'(act_vld[0]), 0);
        pulse(2'b11);
        step_to(53);
        chk("restart_valid", 0, int'(act_vld[0]), 1);
        chk("restart_s11",   0, int'(act_out[0]), -127);
        step_to(60);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
